// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one combinational MIPS ALU between two requesters.
// Round-robin arbitration accepts one operation at a time. The operands are
// registered and driven to the ALU, the result and Zero flag are captured, and
// they are returned on the winning requester's response channel.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/ready/ctl/a/b        request channels (N = 0, 1); ready is combinational
//   rspN_valid/ready                response handshakes (N = 0, 1)
//   rsp_result, rsp_zero, rsp_err   shared response payload
//   alu_ctl, alu_a, alu_b           registered drive to the shared ALU
//   alu_out, alu_zero               shared ALU result
//   busy                            an operation is in flight (EXEC or RESP)
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTLW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CTLW-1:0]  req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CTLW-1:0]  req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CTLW-1:0]  alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_grant;   // requester granted most recently
  logic r_grant;        // requester owning the in-flight operation
  logic w_pick1;
  logic w_accept;
  logic w_rsp_hs;
  logic w_ctl_bad;

  // Round-robin arbitration; ready is gated by rst_n so it reads 0 during reset.
  always_comb begin
    w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
    w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = rst_n && w_accept && !w_pick1;
    req1_ready = rst_n && w_accept && w_pick1;
    w_rsp_hs   = r_grant ? rsp1_ready : rsp0_ready;
  end

  // Legal ALU codes: AND, OR, ADD, SUB, SLT.
  always_comb begin
    w_ctl_bad = 1'b1;
    if (alu_ctl == CTLW'(0) || alu_ctl == CTLW'(1) || alu_ctl == CTLW'(2) ||
        alu_ctl == CTLW'(6) || alu_ctl == CTLW'(7)) begin
      w_ctl_bad = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, result capture and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      alu_ctl      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_ctl      <= w_pick1 ? req1_ctl : req0_ctl;
        alu_a        <= w_pick1 ? req1_a : req0_a;
        alu_b        <= w_pick1 ? req1_b : req0_b;
        r_grant      <= w_pick1;
        r_last_grant <= w_pick1;
      end
      if (r_state == S_EXEC) begin
        rsp_result <= alu_out;
        rsp_zero   <= alu_zero;
        rsp_err    <= w_ctl_bad;
      end
      // r_grant is stable from EXEC through RESP, so it steers the valid bits.
      rsp0_valid <= (w_state_nxt == S_RESP) && !r_grant;
      rsp1_valid <= (w_state_nxt == S_RESP) && r_grant;
      busy       <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl with a behavioural MIPS ALU attached.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .CTLW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // Shared MIPS ALU; unlisted codes produce 0.
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction on requester `port` with rsp_ready held high.
  task automatic run_op(input int port, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err);
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1'b1; req0_ctl = ctl; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_ctl = ctl; req1_a = a; req1_b = b;
    end
    #1;
    chk("op_req0_ready", 32'(req0_ready), 32'(port == 0));
    chk("op_req1_ready", 32'(req1_ready), 32'(port == 1));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("op_exec_busy", 32'(busy), 32'd1);
    chk("op_exec_alu_a", alu_a, a);
    chk("op_exec_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(negedge clk);
    chk("op_rsp0_valid", 32'(rsp0_valid), 32'(port == 0));
    chk("op_rsp1_valid", 32'(rsp1_valid), 32'(port == 1));
    chk("op_result", rsp_result, exp_res);
    chk("op_zero", 32'(rsp_zero), 32'(exp_zero));
    chk("op_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk("op_idle_busy", 32'(busy), 32'd0);
    chk("op_idle_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    chk("op_idle_hold", rsp_result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_alu", {alu_ctl, alu_a[27:0]}, 32'd0);
    rst_n = 1'b1;

    // Basic operations, including SLT and an illegal code.
    run_op(0, 4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op(1, 4'd6, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
    run_op(0, 4'd7, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0);
    run_op(0, 4'd4, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);

    // Backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
    #1 chk("bp_req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd10; req1_b = 32'd20;
    #1 chk("bp_exec_req1_ready", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_result", rsp_result, 32'd3);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk("bp_rel_rsp0", 32'(rsp0_valid), 32'd0);
    chk("bp_rel_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("bp_rsp1_result", rsp_result, 32'd30);
    @(negedge clk);

    // Reset during EXEC drops the operation.
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd100; req0_b = 32'd1;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid_exec_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);

    // Contention after reset: both valid continuously, grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_ctl = 4'd0; req0_a = 32'hF0F0; req0_b = 32'hFF00;
    req1_valid = 1'b1; req1_ctl = 4'd1; req1_a = 32'hF0F0; req1_b = 32'hFF00;
    @(negedge clk);
    chk("rst_hold_ready", 32'(req0_ready | req1_ready), 32'd0);
    chk("rst_hold_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        chk("ct_req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("ct_req1_ready", 32'(req1_ready), 32'(g == 1));
        @(negedge clk);
        chk("ct_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        chk("ct_rsp0_valid", 32'(rsp0_valid), 32'(g == 0));
        chk("ct_rsp1_valid", 32'(rsp1_valid), 32'(g == 1));
        chk("ct_result", rsp_result, (g == 0) ? 32'h0000F000 : 32'h0000FFF0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
